// File: rtl/ctrl_opcode_encoder.sv
// Re-encodes an 11-bit control bundle into the RV32I major opcode behind a 2-entry output FIFO.
// Optional SYSTEM-opcode mode is enabled by defining CTRL_ENC_SYSTEM_EN.
module ctrl_opcode_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      ctrl_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    logic [6:0]       r_op_mem  [2];
    logic             r_ill_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0]       w_opcode;
    logic             w_illegal;
    logic             w_accept;
    logic             w_emit;
    logic [1:0]       w_count_next;

`ifdef CTRL_ENC_SYSTEM_EN
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    logic             r_sys_mode;
    logic             w_is_zero;
`endif

    // Bundle order: {Fence,Auipc,Lui,Jalr,jump,ALUSrc,branch,MemRead,MemWrite,RegWrite,MemtoReg}
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_opcode  = 7'b0000000;
        w_illegal = 1'b0;
`ifdef CTRL_ENC_SYSTEM_EN
        w_is_zero = 1'b0;
`endif
        case (ctrl_in)
            11'h02B: w_opcode = OP_LOAD;
            11'h024: w_opcode = OP_STORE;
            11'h010: w_opcode = OP_BRANCH;
            11'h042: w_opcode = OP_JAL;
            11'h0C2: w_opcode = OP_JALR;
            11'h102: w_opcode = OP_LUI;
            11'h222: w_opcode = OP_AUIPC;
            11'h022: w_opcode = OP_IMM;
            11'h422: w_opcode = OP_FENCE;
`ifdef CTRL_ENC_SYSTEM_EN
            11'h002: w_opcode = r_sys_mode ? OP_SYSTEM : OP_OP;
            11'h000: w_is_zero = 1'b1;
`else
            11'h002: w_opcode = OP_OP;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_accept     = in_valid & r_in_ready;
    assign w_emit       = out_valid & out_ready;
    assign w_count_next = r_count + {1'b0, w_accept} - {1'b0, w_emit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the two buffer slots are reset because the head is visible on the outputs
            // straight out of reset and must read as zero there.
            r_op_mem[0]  <= '0;
            r_op_mem[1]  <= '0;
            r_ill_mem[0] <= 1'b0;
            r_ill_mem[1] <= 1'b0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
            r_in_ready   <= 1'b1;
            r_cnt        <= '0;
`ifdef CTRL_ENC_SYSTEM_EN
            r_sys_mode   <= 1'b0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            if (w_accept) begin
                r_op_mem[r_wptr]  <= w_opcode;
                r_ill_mem[r_wptr] <= w_illegal;
                r_wptr            <= ~r_wptr;
            end
            if (w_emit) begin
                r_rptr <= ~r_rptr;
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < 2'd2);
            if (w_accept && w_illegal && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
`ifdef CTRL_ENC_SYSTEM_EN
            // Legal accepts clear the mode, the all-zero bundle sets it, illegal ones leave it.
            if (w_accept && !w_illegal) begin
                r_sys_mode <= w_is_zero;
            end
`endif
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_count != 2'd0);
    assign opcode_out  = r_op_mem[r_rptr];
    assign illegal_out = r_ill_mem[r_rptr];
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_ctrl_opcode_encoder.sv
// Scoreboard bench for ctrl_opcode_encoder; a second instance with CNT_W=2 checks counter saturation.
// Honours CTRL_ENC_SYSTEM_EN in its reference model when the design is built with it.
module tb_ctrl_opcode_encoder;

    localparam logic [10:0] F_FENCE = 11'h400;
    localparam logic [10:0] F_AUIPC = 11'h200;
    localparam logic [10:0] F_LUI   = 11'h100;
    localparam logic [10:0] F_JALR  = 11'h080;
    localparam logic [10:0] F_JUMP  = 11'h040;
    localparam logic [10:0] F_ALU   = 11'h020;
    localparam logic [10:0] F_BR    = 11'h010;
    localparam logic [10:0] F_MR    = 11'h008;
    localparam logic [10:0] F_MW    = 11'h004;
    localparam logic [10:0] F_RW    = 11'h002;
    localparam logic [10:0] F_MTR   = 11'h001;

    localparam logic [10:0] B_LOAD   = F_MTR | F_RW | F_MR | F_ALU;
    localparam logic [10:0] B_STORE  = F_MW | F_ALU;
    localparam logic [10:0] B_BRANCH = F_BR;
    localparam logic [10:0] B_JAL    = F_RW | F_JUMP;
    localparam logic [10:0] B_JALR   = F_RW | F_JUMP | F_JALR;
    localparam logic [10:0] B_LUI    = F_RW | F_LUI;
    localparam logic [10:0] B_AUIPC  = F_RW | F_ALU | F_AUIPC;
    localparam logic [10:0] B_IMM    = F_RW | F_ALU;
    localparam logic [10:0] B_OP     = F_RW;
    localparam logic [10:0] B_FENCE  = F_RW | F_ALU | F_FENCE;

    typedef struct {
        logic [6:0] op;
        logic       ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] ctrl_in;
    logic        out_ready;
    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [6:0]  opcode_out, opcode_out2;
    logic        illegal_out, illegal_out2;
    logic [7:0]  illegal_cnt;
    logic [1:0]  illegal_cnt2;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_cnt  = 0;
    int          model_cnt2 = 0;
    logic        model_mode = 1'b0;

    logic [10:0] legal_list [10];
    logic [6:0]  legal_ops  [10];

    ctrl_opcode_encoder #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready), .opcode_out(opcode_out),
        .illegal_out(illegal_out), .illegal_cnt(illegal_cnt)
    );

    ctrl_opcode_encoder #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .ctrl_in(ctrl_in),
        .out_valid(out_valid2), .out_ready(out_ready), .opcode_out(opcode_out2),
        .illegal_out(illegal_out2), .illegal_cnt(illegal_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: encodes a bundle and advances the model's mode bit and counters.
    task automatic model_accept(input logic [10:0] b, output exp_t e);
        e.op  = 7'b0000000;
        e.ill = 1'b0;
        if      (b == B_LOAD)   e.op = 7'b0000011;
        else if (b == B_STORE)  e.op = 7'b0100011;
        else if (b == B_BRANCH) e.op = 7'b1100011;
        else if (b == B_JAL)    e.op = 7'b1101111;
        else if (b == B_JALR)   e.op = 7'b1100111;
        else if (b == B_LUI)    e.op = 7'b0110111;
        else if (b == B_AUIPC)  e.op = 7'b0010111;
        else if (b == B_IMM)    e.op = 7'b0010011;
        else if (b == B_FENCE)  e.op = 7'b0001111;
        else if (b == B_OP) begin
`ifdef CTRL_ENC_SYSTEM_EN
            e.op = model_mode ? 7'b1110011 : 7'b0110011;
`else
            e.op = 7'b0110011;
`endif
        end
`ifdef CTRL_ENC_SYSTEM_EN
        else if (b == 11'h000) e.op = 7'b0000000;
`endif
        else e.ill = 1'b1;

`ifdef CTRL_ENC_SYSTEM_EN
        if (!e.ill) model_mode = (b == 11'h000);
`endif
        if (e.ill) begin
            if (model_cnt  < 255) model_cnt++;
            if (model_cnt2 < 3)   model_cnt2++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [10:0] b);
        exp_t e;
        int   waited = 0;
        in_valid = 1'b1;
        ctrl_in  = b;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            model_accept(b, e);
            sb.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ctrl_in  = $urandom_range(0, 2047);
    endtask

    task automatic drain();
        int waited = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain_done", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        model_cnt  = 0;
        model_cnt2 = 0;
        model_mode = 1'b0;
    endtask

    // Pop and compare each emitted entry; during a stall the head must already match.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {25'd0, opcode_out}, 32'hFFFF_FFFF);
            end else if (out_ready) begin
                check("out_opcode",  {25'd0, opcode_out}, {25'd0, sb[0].op});
                check("out_illegal", {31'd0, illegal_out}, {31'd0, sb[0].ill});
                void'(sb.pop_front());
            end else begin
                check("stall_opcode", {25'd0, opcode_out}, {25'd0, sb[0].op});
            end
        end
    end

    initial begin
        legal_list = '{B_LOAD, B_STORE, B_BRANCH, B_JAL, B_JALR, B_LUI, B_AUIPC, B_IMM, B_OP, B_FENCE};
        legal_ops  = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                       7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b0001111};
        in_valid  = 1'b0;
        ctrl_in   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        check("rst_out_valid",   {31'd0, out_valid},   32'd0);
        check("rst_in_ready",    {31'd0, in_ready},    32'd1);
        check("rst_opcode",      {25'd0, opcode_out},  32'd0);
        check("rst_illegal",     {31'd0, illegal_out}, 32'd0);
        check("rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);

        // One-cycle latency on a LOAD bundle.
        out_ready = 1'b1;
        send(B_LOAD);
        check("load_out_valid", {31'd0, out_valid},    32'd1);
        check("load_opcode",    {25'd0, opcode_out},   32'h03);
        check("load_illegal",   {31'd0, illegal_out},  32'd0);
        check("load_cnt",       {24'd0, illegal_cnt},  32'd0);
        drain();

        // Fill the buffer while stalled, third bundle must wait for space.
        out_ready = 1'b0;
        send(B_STORE);
        send(B_BRANCH);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        fork
            send(B_JALR);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("held_in_ready", {31'd0, in_ready},   32'd0);
                check("held_head",     {25'd0, opcode_out}, 32'h23);
                out_ready = 1'b1;
            end
        join
        drain();

        // Illegal bundles and counters.
        send(11'h7FF);
        check("ill_opcode",  {25'd0, opcode_out},  32'd0);
        check("ill_flag",    {31'd0, illegal_out}, 32'd1);
        check("ill_cnt_1",   {24'd0, illegal_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) send(11'h7FF);
        drain();
        check("ill_cnt_5",   {24'd0, illegal_cnt},  model_cnt);
        check("ill_cnt2_sat", {30'd0, illegal_cnt2}, 32'd3);

        // Stream all legal bundles at full rate.
        for (int i = 0; i < 10; i++) begin
            send(legal_list[i]);
            check("stream_opcode",   {25'd0, opcode_out}, {25'd0, legal_ops[i]});
            check("stream_in_ready", {31'd0, in_ready},   32'd1);
        end
        drain();

        // All-zero then RegWrite-only, then LUI followed by RegWrite-only.
        send(11'h000);
        send(B_OP);
        send(B_LUI);
        send(B_OP);
        drain();
        check("sys_seq_cnt", {24'd0, illegal_cnt}, model_cnt);

        // Saturation of the 8-bit counter.
        for (int i = 0; i < 260; i++) send(11'h400 | 11'($urandom_range(0, 1)));
        drain();
        check("sat_cnt",  {24'd0, illegal_cnt},  32'd255);
        check("sat_cnt2", {30'd0, illegal_cnt2}, 32'd3);

        // Reset with a full buffer discards everything.
        out_ready = 1'b0;
        send(11'h7FF);
        send(11'h7FE);
        check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        do_reset();
        check("mid_rst_out_valid", {31'd0, out_valid},    32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready},     32'd1);
        check("mid_rst_cnt",       {24'd0, illegal_cnt},  32'd0);
        check("mid_rst_opcode",    {25'd0, opcode_out},   32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        send(B_FENCE);
        check("post_rst_fence", {25'd0, opcode_out}, 32'h0F);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
